multi_humidity_ctrl: RTL and testbench

MULTI_HUMIDITY_CTRL -- requirements
Module: multi_humidity_ctrl

---
 rtl/multi_humidity_ctrl.sv | 160 ++++++++++++++++
 tb/tb_multi_humidity_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/multi_humidity_ctrl.sv
// Per-channel humidity FSMs (NORMAL/WET/DRY) with persistence filtering, fan/alert drive and a shared buzzer.
// Define HUMIDITY_ALERT_LATCH_EN to make alerts sticky until acknowledged while the channel is NORMAL.

module humidity_chan #(
    parameter int DW      = 8,
    parameter int HIGH    = 65,
    parameter int LOW     = 40,
    parameter int HYST    = 3,
    parameter int PERSIST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample_valid,
    input  logic [DW-1:0] sample,
    input  logic          alert_ack,
    output logic          fan_on,
    output logic          alert
);
    typedef enum logic [1:0] {NORMAL, WET, DRY} state_t;

    localparam int             CW       = $clog2(PERSIST + 1);
    localparam logic [CW-1:0]  P_MAX    = CW'(PERSIST);
    localparam logic [31:0]    HI_T     = 32'(HIGH);
    localparam logic [31:0]    LO_T     = 32'(LOW);
    localparam logic [31:0]    WET_EXIT = 32'(HIGH - HYST);
    localparam logic [31:0]    DRY_EXIT = 32'(LOW + HYST);
    localparam logic [31:0]    RH_MAX   = 32'd100;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic          dir, dir_n, qual, want_dir;
    logic [31:0]   s;

    assign s = 32'(sample);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        dir_n    = dir;
        qual     = 1'b0;
        want_dir = dir;
        cnt_inc  = cnt + 1'b1;
        // Out-of-range samples (>100 %RH) are treated as if no sample arrived.
        if (sample_valid && s <= RH_MAX) begin
            case (state)
                NORMAL: begin
                    if (s > HI_T) begin
                        qual     = 1'b1;
                        want_dir = 1'b1;
                    end else if (s < LO_T) begin
                        qual     = 1'b1;
                        want_dir = 1'b0;
                    end
                    if (want_dir != dir)
                        cnt_inc = CW'(1);
                    dir_n = want_dir;
                end
                WET:     qual = (s <= WET_EXIT);
                DRY:     qual = (s >= DRY_EXIT);
                default: qual = 1'b0;
            endcase
            if (!qual) begin
                cnt_n = '0;
            end else if (cnt_inc == P_MAX) begin
                cnt_n   = '0;
                state_n = (state == NORMAL) ? (want_dir ? WET : DRY) : NORMAL;
            end else begin
                cnt_n = cnt_inc;
            end
        end
        if (state == 2'b11)
            state_n = NORMAL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= NORMAL;
            cnt   <= '0;
            dir   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            dir   <= dir_n;
        end
    end

    assign fan_on = (state == WET);

`ifdef HUMIDITY_ALERT_LATCH_EN
    logic alert_q;
    // Entry into an abnormal state beats a same-cycle ack.
    always_ff @(posedge clk) begin
        if (rst)
            alert_q <= 1'b0;
        else if (state == NORMAL && state_n != NORMAL)
            alert_q <= 1'b1;
        else if (alert_ack && state == NORMAL)
            alert_q <= 1'b0;
    end
    assign alert = alert_q;
`else
    logic unused_ack;
    assign unused_ack = alert_ack;
    assign alert      = (state != NORMAL);
`endif
endmodule

module multi_humidity_ctrl #(
    parameter int N_CH     = 4,
    parameter int DW       = 8,
    parameter int HIGH     = 65,
    parameter int LOW      = 40,
    parameter int HYST     = 3,
    parameter int PERSIST  = 4,
    parameter int BUZZ_DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_valid,
    input  logic [N_CH*DW-1:0] humidity,
    input  logic [N_CH-1:0]    alert_ack,
    output logic [N_CH-1:0]    fan_on,
    output logic [N_CH-1:0]    alert,
    output logic               any_alert,
    output logic               buzzer
);
    localparam int            BW    = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;
    localparam logic [BW-1:0] B_TOP = BW'(BUZZ_DIV - 1);

    logic [BW-1:0] bcnt;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        humidity_chan #(
            .DW(DW), .HIGH(HIGH), .LOW(LOW), .HYST(HYST), .PERSIST(PERSIST)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .sample_valid (sample_valid),
            .sample       (humidity[i*DW +: DW]),
            .alert_ack    (alert_ack[i]),
            .fan_on       (fan_on[i]),
            .alert        (alert[i])
        );
    end

    assign any_alert = |alert;

    // Buzzer phase restarts from zero every time an alert episode begins.
    always_ff @(posedge clk) begin
        if (rst || !any_alert) begin
            bcnt   <= '0;
            buzzer <= 1'b0;
        end else if (bcnt == B_TOP) begin
            bcnt   <= '0;
            buzzer <= ~buzzer;
        end else begin
            bcnt   <= bcnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_multi_humidity_ctrl.sv
// Directed bench for multi_humidity_ctrl at default parameters; expectations adapt to HUMIDITY_ALERT_LATCH_EN.
module tb_multi_humidity_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic [31:0] humidity;
    logic [3:0]  alert_ack;
    logic [3:0]  fan_on, alert;
    logic        any_alert, buzzer;
    logic [7:0]  h [4];
    int          n_chk = 0;
    int          n_err = 0;

`ifdef HUMIDITY_ALERT_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    multi_humidity_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .humidity     (humidity),
        .alert_ack    (alert_ack),
        .fan_on       (fan_on),
        .alert        (alert),
        .any_alert    (any_alert),
        .buzzer       (buzzer)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [3:0] ack = 4'b0000);
        humidity     = {h[3], h[2], h[1], h[0]};
        sample_valid = v;
        alert_ack    = ack;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        alert_ack    = 4'b0000;
    endtask

    initial begin
        rst = 1'b1;
        sample_valid = 1'b0;
        alert_ack = 4'b0000;
        for (int i = 0; i < 4; i++) h[i] = 8'd50;
        repeat (2) step(1'b0);
        chk("rst_fan", 32'(fan_on), 32'h0);
        chk("rst_alert", 32'(alert), 32'h0);
        chk("rst_any", 32'(any_alert), 32'h0);
        chk("rst_buzz", 32'(buzzer), 32'h0);
        rst = 1'b0;

        // three wet samples then an in-band one: count must clear
        h[0] = 8'd70; h[1] = 8'd70;
        repeat (3) step(1'b1);
        h[0] = 8'd60; h[1] = 8'd60;
        step(1'b1);
        chk("p1_no_fan", 32'(fan_on), 32'h0);
        h[0] = 8'd70; h[1] = 8'd70;
        repeat (3) step(1'b1);
        chk("p1_3rd", 32'(fan_on), 32'h0);
        step(1'b1);
        chk("p1_fan", 32'(fan_on), 32'h3);
        chk("p1_alert", 32'(alert), 32'h3);
        chk("p1_any", 32'(any_alert), 32'h1);
        chk("p1_buzz0", 32'(buzzer), 32'h0);

        // buzzer toggles every BUZZ_DIV cycles from alert onset
        repeat (3) step(1'b0);
        chk("bz_e3", 32'(buzzer), 32'h0);
        step(1'b0);
        chk("bz_e4", 32'(buzzer), 32'h1);
        repeat (3) step(1'b0);
        chk("bz_e7", 32'(buzzer), 32'h1);
        step(1'b0);
        chk("bz_e8", 32'(buzzer), 32'h0);

        step(1'b0, 4'b0011);
        chk("ack_wet", 32'(alert), 32'h3);

        // ch1: 63 is above the wet exit threshold (62), 62 is not
        h[1] = 8'd63;
        repeat (4) step(1'b1);
        chk("c1_63", 32'(fan_on), 32'h3);
        h[1] = 8'd62;
        repeat (3) step(1'b1);
        chk("c1_62_3", 32'(fan_on), 32'h3);
        step(1'b1);
        chk("c1_norm", 32'(fan_on), 32'h1);
        chk("c1_alert", 32'(alert), LATCH ? 32'h3 : 32'h1);

        // ch2: direction change restarts the count
        h[1] = 8'd50;
        h[2] = 8'd35;
        repeat (2) step(1'b1);
        chk("c2_dry2", 32'(alert[2]), 32'h0);
        h[2] = 8'd70;
        repeat (3) step(1'b1);
        chk("c2_wet3", 32'(fan_on[2]), 32'h0);
        step(1'b1);
        chk("c2_wet", 32'(fan_on), 32'h5);

        h[0] = 8'd62; h[2] = 8'd62;
        repeat (4) step(1'b1);
        chk("ret_fan", 32'(fan_on), 32'h0);
        chk("ret_alert", 32'(alert), LATCH ? 32'h7 : 32'h0);
        step(1'b0, 4'b1111);
        chk("ack_norm", 32'(alert), 32'h0);
        chk("ack_any", 32'(any_alert), 32'h0);
        step(1'b0);
        chk("bz_off", 32'(buzzer), 32'h0);

        // ch3: sparse valid pulses with one out-of-range sample
        h[0] = 8'd50; h[2] = 8'd50; h[3] = 8'd30;
        step(1'b1); repeat (4) step(1'b0);
        step(1'b1); repeat (4) step(1'b0);
        chk("c3_2", 32'(alert), 32'h0);
        h[3] = 8'd200;
        step(1'b1);
        h[3] = 8'd30;
        repeat (4) step(1'b0);
        chk("c3_200", 32'(alert), 32'h0);
        step(1'b1); repeat (4) step(1'b0);
        chk("c3_3", 32'(alert), 32'h0);
        step(1'b1);
        chk("c3_dry", 32'(alert), 32'h8);
        chk("c3_fan", 32'(fan_on), 32'h0);

        // reset mid-count must abort the partial persistence count
        h[3] = 8'd50; h[0] = 8'd70;
        repeat (2) step(1'b1);
        rst = 1'b1;
        step(1'b1, 4'b1111);
        chk("mr_fan", 32'(fan_on), 32'h0);
        chk("mr_alert", 32'(alert), 32'h0);
        chk("mr_any", 32'(any_alert), 32'h0);
        chk("mr_buzz", 32'(buzzer), 32'h0);
        rst = 1'b0;
        repeat (3) step(1'b1);
        chk("mr_3", 32'(fan_on), 32'h0);
        step(1'b1);
        chk("mr_4", 32'(fan_on), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
